sipo_deframer: RTL

Parametrised serial-in/parallel-out deserializer, successor to the fixed 10-bit free-running shifter.
- Accumulates WIDTH qualified serial bits into a word.
- Presents each completed word on a held output register with a valid/ready handshake.
- Flags overruns and supports frame resynchronisation and selectable bit order.
- Sits between the serial receive front end and word-level consumers (register file / FIFO write side).

---
 rtl/sipo_deframer_pkg.sv | 13 +
 rtl/sipo_deframer_if.sv | 29 ++
 rtl/sipo_shift_core.sv | 58 +++++
 rtl/sipo_deframer.sv | 92 +++++++++
 4 files changed

// File: rtl/sipo_deframer_pkg.sv
// Shared constants for the SIPO deframer and its matching PISO serializer:
// bit-order encodings and the output-stage state type.
package sipo_deframer_pkg;

    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial-in / word-out bundle. The master drives the serial bits and the
// consumer controls; the slave is the deframer.
interface sipo_deframer_if #(
    parameter int WIDTH = 10
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Handshake: a word transfers on every rising edge where word_valid and
    // word_ready are both 1; data_out is held stable while word_valid is 1.
    logic             bit_valid;
    logic             data_in;
    logic             frame_start;
    logic             word_ready;
    logic             clr_overrun;
    logic [WIDTH-1:0] data_out;
    logic             word_valid;
    logic             overrun;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output bit_valid, data_in, frame_start, word_ready, clr_overrun,
        input  data_out, word_valid, overrun, bit_count
    );

    modport slave (
        input  bit_valid, data_in, frame_start, word_ready, clr_overrun,
        output data_out, word_valid, overrun, bit_count
    );
endinterface

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter: assembles WIDTH qualified bits and emits a
// one-cycle completion pulse alongside the finished word.
module sipo_shift_core
    import sipo_deframer_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_bit_valid,
    input  logic             i_data_in,
    input  logic             i_frame_start,
    output logic [WIDTH-1:0] o_word,
    output logic             o_done,
    output logic [CNT_W-1:0] o_bit_count
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_first;

    always_comb begin
        if (MSB_FIRST == ORDER_MSB_FIRST) begin
            w_shifted = {r_shift[WIDTH-2:0], i_data_in};
            w_first   = {{(WIDTH-1){1'b0}}, i_data_in};
        end else begin
            w_shifted = {i_data_in, r_shift[WIDTH-1:1]};
            w_first   = {i_data_in, {(WIDTH-1){1'b0}}};
        end
    end

    // frame_start suppresses completion even on what would be the last bit.
    assign o_done      = i_bit_valid && !i_frame_start && (r_count == LAST_IDX);
    assign o_word      = w_shifted;
    assign o_bit_count = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_frame_start) begin
            if (i_bit_valid) begin
                r_shift <= w_first;
                r_count <= CNT_W'(1);
            end else begin
                r_count <= '0;
            end
        end else if (i_bit_valid) begin
            r_shift <= w_shifted;
            r_count <= o_done ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// Serial deframer top: shift core plus a held output word with valid/ready
// handshake and a sticky overrun flag for words that found the output full.
module sipo_deframer
    import sipo_deframer_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic            clk,
    input  logic            reset,
    sipo_deframer_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic [CNT_W-1:0] w_bit_count;

    out_state_e       r_state;
    out_state_e       w_next_state;
    logic [WIDTH-1:0] r_data_out;
    logic             r_overrun;
    logic             w_load;
    logic             w_drop;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk           (clk),
        .reset         (reset),
        .i_bit_valid   (bus.bit_valid),
        .i_data_in     (bus.data_in),
        .i_frame_start (bus.frame_start),
        .o_word        (w_word),
        .o_done        (w_done),
        .o_bit_count   (w_bit_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_data_out <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_data_out <= w_word;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // A completing word replaces the held one only if the held one is being
    // consumed on the same edge; otherwise it is dropped.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_done) begin
                    w_load       = 1'b1;
                    w_next_state = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_done) begin
                    if (bus.word_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (bus.word_ready) begin
                    w_next_state = ST_EMPTY;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    assign bus.data_out   = r_data_out;
    assign bus.word_valid = (r_state == ST_FULL);
    assign bus.overrun    = r_overrun;
    assign bus.bit_count  = w_bit_count;

endmodule
